// File: rtl/halve_tokens_if.sv
// Token-halver port bundle: input token stream plus the buffered output handshake and status flags.
interface halve_tokens_if #(
    parameter int CNT_W = 4
);
    logic             a;
    logic             b_ready;
    logic             b;
    logic [CNT_W-1:0] pending;
    logic             orphan;
    logic             overflow;

    modport master (
        output a, b_ready,
        input  b, pending, orphan, overflow
    );

    modport slave (
        input  a, b_ready,
        output b, pending, orphan, overflow
    );
endinterface

// File: rtl/halve_tokens.sv
// One output token per two input tokens; b rises 1 cycle after the pairing edge.
// Pairs buffer in a saturating counter while b_ready is low; a pair arriving at saturation is lost and flagged.
module halve_tokens #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          rst,
    halve_tokens_if.slave tok
);
    localparam int                IDLE_W    = $clog2(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [IDLE_W-1:0] idle_cnt, idle_nxt;
    logic [CNT_W-1:0]  pending, pending_nxt;
    logic              inc, timeout, dec, lost;
    logic              orphan, overflow;

    always_comb begin
        state_nxt = state;
        idle_nxt  = '0;
        inc       = 1'b0;
        timeout   = 1'b0;
        if (state == EMPTY) begin
            if (tok.a) begin
                state_nxt = HALF;
            end
        end else begin
            if (tok.a) begin
                // A token on the would-be timeout cycle still pairs.
                state_nxt = EMPTY;
                inc       = 1'b1;
            end else if (idle_cnt == IDLE_LAST) begin
                state_nxt = EMPTY;
                timeout   = 1'b1;
            end else begin
                idle_nxt  = idle_cnt + IDLE_W'(1);
            end
        end
    end

    always_comb begin
        dec         = (pending != '0) && tok.b_ready;
        pending_nxt = pending;
        lost        = 1'b0;
        case ({inc, dec})
            2'b10: begin
                if (pending == CNT_MAX) begin
                    lost = 1'b1;
                end else begin
                    pending_nxt = pending + CNT_W'(1);
                end
            end
            2'b01:   pending_nxt = pending - CNT_W'(1);
            default: pending_nxt = pending;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= EMPTY;
            idle_cnt <= '0;
            pending  <= '0;
            orphan   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_nxt;
            pending  <= pending_nxt;
            orphan   <= timeout;
            overflow <= overflow | lost;
        end
    end

    assign tok.b        = (pending != '0);
    assign tok.pending  = pending;
    assign tok.orphan   = orphan;
    assign tok.overflow = overflow;
endmodule

// File: doc/halve_tokens.md
# halve_tokens

Token-rate halver: the receive-side counterpart of the token doubler in the sequential-basics set. It consumes a single-bit token stream on `a` and emits one output token on `b` for every two input tokens. Output tokens are buffered in a saturating credit counter behind a `b`/`b_ready` handshake. An unpaired token that is stranded by an idle input is dropped after a timeout and reported. It sits directly downstream of a doubling stage, so a doubler-to-halver chain reproduces the original token count.

## Interface

Parameters:
- `CNT_W`, default 4: width of the pending-token counter; saturates at 2^CNT_W-1.
- `TIMEOUT`, default 8: idle cycles (≥2) after which an unpaired input token is discarded.

Ports:
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `a`  in  1: input token; one token per cycle sampled high.
- `b_ready`  in  1: downstream accepts an output token this cycle.
- `b`  out  1: output token offered; transfer when `b & b_ready`.
- `pending`  out  CNT_W: registered count of buffered output tokens.
- `orphan`  out  1: one-cycle pulse; an unpaired token was discarded by timeout.
- `overflow`  out  1: sticky; a completed pair was lost because `pending` was saturated.

## Operation

State:
- `half` (1 bit): an unpaired token is held.
- `idle_cnt` (clog2(TIMEOUT) bits).
- `pending` (CNT_W).
- `orphan` and `overflow` registers.

Reset (rst low, async): `half`=0, `idle_cnt`=0, `pending`=0, `orphan`=0, `overflow`=0. Consequently `b`=0. Reset mid-operation discards `half` and all pending tokens without raising `orphan` or `overflow`.

Pairing FSM, two states, EMPTY (`half`=0) and HALF (`half`=1):
- EMPTY, a=1 → HALF; `idle_cnt`←0.
- HALF, a=1 → EMPTY; a pair completes (inc=1).
- HALF, a=0, `idle_cnt`<TIMEOUT-1 → stay in HALF; `idle_cnt`+1.
- HALF, a=0, `idle_cnt`==TIMEOUT-1 → EMPTY; `idle_cnt`←0; `orphan`←1 for exactly the next cycle.
- If a=1 arrives on the cycle that would have timed out, it pairs; no orphan is raised.
- `orphan` is 0 in every cycle not following a timeout edge.

Output buffer:
- `b` = (`pending` != 0), combinational from the register.
- dec = `b & b_ready`.
- inc=1, dec=0: `pending`+1, unless saturated at 2^CNT_W-1. When saturated, `pending` holds, the token is lost, and `overflow`←1.
- inc=1, dec=1: `pending` unchanged, including when saturated. No overflow.
- inc=0, dec=1: `pending`-1.
- `overflow` clears only on reset.
- `b_ready` while `b`=0 has no effect. `pending` never underflows.

## Timing

- Latency from the second `a` of a pair (sampled at edge k) to `b` high is 1 cycle: `b` is high in the cycle after edge k.
- With `b_ready` held at 1 and `pending` at 0, each pair yields exactly one `b` cycle.
- Continuous a=1 with `b_ready`=1 gives `b` high every other cycle.
- Back-to-back transfers: `b` stays high across consecutive cycles while `pending`>1 and `b_ready`=1.
- Orphan: with the single token sampled at edge k and a=0 afterward, `half` clears at edge k+TIMEOUT. `orphan` is high during cycle k+TIMEOUT+1 only.
- `overflow` rises in the cycle after the losing edge.

## Test plan

- Reset: assert rst low mid-stream with `pending`=5 and `half`=1. Require `b`=0, `pending`=0, `orphan`=0, `overflow`=0 immediately (async), and no orphan after release.
- Steady pairing: `b_ready`=1, a=1 for 6 cycles, then 0. Require exactly 3 `b` cycles, each one cycle after edges 2, 4 and 6; final `pending`=0.
- Backpressure: `b_ready`=0, 10 tokens. Require `pending`=5 and `b` held high. Then `b_ready`=1: `b` high exactly 5 consecutive cycles, then 0.
- Saturation: CNT_W=4, `b_ready`=0, a=1 for 34 cycles.
  - `pending` reaches 15 at the 30th token and stays there.
  - `overflow` is 0 through token 31 and sets after token 32, then stays 1.
  - Pulsing `b_ready` on the saturated count with a simultaneous pair keeps `pending`=15 and does not add extra overflow events.
- Orphan: single token, then a=0 for 8 cycles. Require one `orphan` pulse at the specified cycle; then 2 tokens give one `b`. Repeat with the second token on the 8th idle cycle: no orphan, one `b`.
- Loopback: doubler → halver, with 30%-density random `a` for 100 cycles, `b_ready`=1, then 200 idle cycles. Require count of `b & b_ready` == input token count, `orphan` never high, `overflow`=0.
